mat_host_loader: RTL and testbench
==================================

// Module: mat_host_loader
// PURPOSE
//  Host-side sequencer upstream of BRAM_Matrix/DMA_Controller. Accepts a WIDTH-bit element
//  stream of A then B (row-major), packs N elements per row, and writes the rows through the
//  A/B USR ports. It then pulses start to the DMA and counts C_MAT_wr row writes until
//  completion. Finally it reads C back via the C USR port and streams C elements out.
// PARAMETERS
//  N        6                  matrix dimension (rows = cols)
//  WIDTH    16                 A/B element width
//  M_WIDTH  2*WIDTH+N-1 (=37)  C element width
//  ADDR     CLOG2(N) (=3)      row address width
// PORTS
//  clk         in   1          single clock; all logic on posedge
//  rst_n       in   1          reset, asynchronous, active-low
//  s_valid     in   1          input element valid
//  s_ready     out  1          input element accepted when s_valid&&s_ready
//  s_data      in   WIDTH      A/B element, row-major, A first then B
//  m_valid     out  1          output C element valid
//  m_ready     in   1          downstream accepts C element
//  m_data      out  M_WIDTH    C element, row-major
//  busy        out  1          high in every state except IDLE
//  A_USR_wr    out  1          A row write strobe
//  A_USR_addr  out  ADDR       A row address
//  A_USR_din   out  N*WIDTH    packed A row
//  B_USR_wr/B_USR_addr/B_USR_din  out  1/ADDR/N*WIDTH  as A, for B
//  C_USR_rd    out  1          C row read strobe
//  C_USR_addr  out  ADDR       C row address
//  C_USR_dout  in   N*M_WIDTH  C row data, valid the cycle after C_USR_rd
//  start       out  1          DMA start
//  C_MAT_wr    in   1          DMA C row write strobe (monitored only)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; reset mid-operation aborts, no partial writes.
//  Packing: element k of a row -> bits [k*WIDTH +: WIDTH] (element 0 at LSBs); same for C.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> START -> WAIT -> READ -> DRAIN -> (READ | IDLE).
//  IDLE: s_ready=0; first cycle with s_valid=1 moves to LOAD_A (element not consumed).
//  LOAD_A/LOAD_B: s_ready=1. Column counter 0..N-1 and row counter 0..N-1.
//   - On acceptance of element N-1 of a row: *_USR_wr=1 for exactly one cycle on the next
//     cycle, with addr=row and din=full packed row. s_ready stays 1 (no bubble).
//   - After row N-1 of A: go to LOAD_B. After row N-1 of B: go to START.
//  START: start=1 for exactly 3 consecutive cycles, then WAIT; s_ready=0.
//  WAIT: count C_MAT_wr pulses. On the N-th pulse, go to READ next cycle with row=0.
//   C_MAT_wr outside WAIT is ignored.
//  READ: C_USR_rd=1, C_USR_addr=row for one cycle. Next cycle: latch C_USR_dout into the
//   row buffer and enter DRAIN.
//  DRAIN: m_valid=1, m_data=element col of the buffered row. Advance col on m_valid&&m_ready.
//   m_data is held stable while m_ready=0. After col N-1: row<N-1 -> READ(row+1),
//   else -> IDLE.
//  Throughput: >=2 idle output cycles between C rows (read latency); none within a row.
//  busy=1 in all states except IDLE; start never reasserts until the next IDLE->LOAD_A.
// TESTING
//  1 A rows=B rows={1,2,3,4,5,6} (72 elements, s_valid held high) -> 6 A writes with
//    din=96'h000600050004000300020001, then 6 B writes with the same din, then start high
//    for 3 cycles.
//  2 Same as 1, DMA completes, m_ready=1 -> 36 C elements; each row is
//    {21,42,63,84,105,126}; then busy=0.
//  3 A=identity, B=rows {1..6} -> C rows equal B rows. Toggle m_ready 1/0 every cycle ->
//    m_data stable while m_ready=0, no element lost or duplicated.
//  4 s_valid gapped (1 in 3 cycles) -> write contents and addresses identical to scenario 1.
//    No write strobe before a row is complete.
//  5 Assert rst_n=0 during LOAD_B row 2 -> all outputs 0 immediately. Release and reload ->
//    full correct run as in 2.
//  6 Inject C_MAT_wr pulses in LOAD_A -> ignored; WAIT still requires exactly 6 pulses.

Source files
------------

// File: rtl/mat_host_loader.sv
// Host sequencer: packs A/B element stream into BRAM rows, starts the DMA, waits for N C rows, streams C back out.
// Row writes land 1 cycle after the last element of a row; s_ready only in load states; m_data holds while m_ready=0.
module mat_host_loader #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int ADDR    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [M_WIDTH-1:0]   m_data,
  output logic                 busy,
  output logic                 A_USR_wr,
  output logic [ADDR-1:0]      A_USR_addr,
  output logic [N*WIDTH-1:0]   A_USR_din,
  output logic                 B_USR_wr,
  output logic [ADDR-1:0]      B_USR_addr,
  output logic [N*WIDTH-1:0]   B_USR_din,
  output logic                 C_USR_rd,
  output logic [ADDR-1:0]      C_USR_addr,
  input  logic [N*M_WIDTH-1:0] C_USR_dout,
  output logic                 start,
  input  logic                 C_MAT_wr
);

  localparam int CW = $clog2(N+1);
  localparam logic [ADDR-1:0] LAST = ADDR'(N-1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT, READ, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR-1:0]      col, row;
  logic [1:0]           st_cnt;
  logic [CW-1:0]        wcnt;
  logic                 rd_pend;
  logic [N*WIDTH-1:0]   pack, pack_nxt;
  logic [N*M_WIDTH-1:0] cbuf;
  logic                 s_acc;
  logic                 row_done;

  assign s_acc    = s_valid && (state == LOAD_A || state == LOAD_B);
  assign row_done = s_acc && (col == LAST);

  always_comb begin
    pack_nxt = pack;
    pack_nxt[col*WIDTH +: WIDTH] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = LOAD_A;
      LOAD_A:  if (row_done && row == LAST) state_nxt = LOAD_B;
      LOAD_B:  if (row_done && row == LAST) state_nxt = START;
      START:   if (st_cnt == 2'd2) state_nxt = WAIT;
      WAIT:    if (C_MAT_wr && wcnt == CW'(N-1)) state_nxt = READ;
      READ:    if (rd_pend) state_nxt = DRAIN;
      DRAIN:   if (m_ready && col == LAST) state_nxt = (row == LAST) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = (state == LOAD_A) || (state == LOAD_B);
    start      = (state == START);
    busy       = (state != IDLE);
    m_valid    = (state == DRAIN);
    m_data     = (state == DRAIN) ? cbuf[col*M_WIDTH +: M_WIDTH] : '0;
    C_USR_rd   = (state == READ) && !rd_pend;
    C_USR_addr = (state == READ) ? row : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      st_cnt     <= '0;
      wcnt       <= '0;
      rd_pend    <= 1'b0;
      pack       <= '0;
      cbuf       <= '0;
      A_USR_wr   <= 1'b0;
      A_USR_addr <= '0;
      A_USR_din  <= '0;
      B_USR_wr   <= 1'b0;
      B_USR_addr <= '0;
      B_USR_din  <= '0;
    end else begin
      A_USR_wr <= 1'b0;
      B_USR_wr <= 1'b0;
      st_cnt   <= (state == START) ? st_cnt + 2'd1 : 2'd0;
      wcnt     <= (state == WAIT && C_MAT_wr) ? wcnt + CW'(1) : (state == WAIT ? wcnt : '0);
      rd_pend  <= (state == READ) ? !rd_pend : 1'b0;
      case (state)
        LOAD_A, LOAD_B: begin
          if (s_acc) begin
            pack <= pack_nxt;
            if (col == LAST) begin
              col <= '0;
              row <= (row == LAST) ? '0 : row + 1'b1;
              // Strobe goes out the cycle after the row's last element is accepted.
              if (state == LOAD_A) begin
                A_USR_wr   <= 1'b1;
                A_USR_addr <= row;
                A_USR_din  <= pack_nxt;
              end else begin
                B_USR_wr   <= 1'b1;
                B_USR_addr <= row;
                B_USR_din  <= pack_nxt;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        READ: begin
          if (rd_pend) cbuf <= C_USR_dout;
        end
        DRAIN: begin
          if (m_ready) begin
            if (col == LAST) begin
              col <= '0;
              row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        IDLE: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_host_loader.sv
// Randomized bench for mat_host_loader with BRAM/DMA environment model and scoreboard queues.
module tb_mat_host_loader;
  localparam int N = 6;
  localparam int W = 16;
  localparam int MW = 2*W+N-1;
  localparam int AW = $clog2(N);

  logic clk, rst_n;
  logic s_valid, s_ready;
  logic [W-1:0] s_data;
  logic m_valid, m_ready;
  logic [MW-1:0] m_data;
  logic busy;
  logic A_USR_wr, B_USR_wr, C_USR_rd, start, C_MAT_wr;
  logic [AW-1:0] A_USR_addr, B_USR_addr, C_USR_addr;
  logic [N*W-1:0] A_USR_din, B_USR_din;
  logic [N*MW-1:0] C_USR_dout;

  mat_host_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy),
    .A_USR_wr(A_USR_wr), .A_USR_addr(A_USR_addr), .A_USR_din(A_USR_din),
    .B_USR_wr(B_USR_wr), .B_USR_addr(B_USR_addr), .B_USR_din(B_USR_din),
    .C_USR_rd(C_USR_rd), .C_USR_addr(C_USR_addr), .C_USR_dout(C_USR_dout),
    .start(start), .C_MAT_wr(C_MAT_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nfail = 0;

  logic [AW+N*W-1:0] exp_a[$];
  logic [AW+N*W-1:0] exp_b[$];
  logic [MW-1:0]     exp_c[$];
  logic [N*W-1:0]    amem[8];
  logic [N*W-1:0]    bmem[8];
  logic [N*MW-1:0]   cmem[8];
  logic [W-1:0]      ma[N][N];
  logic [W-1:0]      mb[N][N];

  int acc_cnt, start_cycles, rd_cnt, mr_mode;
  logic hold_pend;
  logic [MW-1:0] hold_dat;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: everything sampled mid-cycle on negedge; all drivers change at posedge+1.
  initial begin : monitor
    logic [AW+N*W-1:0] e;
    logic [MW-1:0] ec;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (A_USR_wr) begin
          amem[A_USR_addr] = A_USR_din;
          if (exp_a.size() == 0) chk("a_wr_unexpected", 256'(A_USR_addr), 256'hDEAD);
          else begin
            e = exp_a.pop_front();
            chk("a_wr_row", 256'({A_USR_addr, A_USR_din}), 256'(e));
          end
          chk("a_wr_after_row", 256'(acc_cnt), 256'((int'(A_USR_addr)+1)*N));
        end
        if (B_USR_wr) begin
          bmem[B_USR_addr] = B_USR_din;
          if (exp_b.size() == 0) chk("b_wr_unexpected", 256'(B_USR_addr), 256'hDEAD);
          else begin
            e = exp_b.pop_front();
            chk("b_wr_row", 256'({B_USR_addr, B_USR_din}), 256'(e));
          end
          chk("b_wr_after_row", 256'(acc_cnt), 256'(N*N + (int'(B_USR_addr)+1)*N));
        end
        if (s_valid && s_ready) acc_cnt++;
        if (start) start_cycles++;
        if (C_USR_rd) begin
          chk("c_rd_addr", 256'(C_USR_addr), 256'(rd_cnt));
          rd_cnt++;
        end
        if (hold_pend) chk("m_hold", 256'({m_valid, m_data}), 256'({1'b1, hold_dat}));
        hold_pend = m_valid && !m_ready;
        hold_dat  = m_data;
        if (m_valid && m_ready) begin
          if (exp_c.size() == 0) chk("c_unexpected", 256'(m_data), 256'hDEAD);
          else begin
            ec = exp_c.pop_front();
            chk("c_elem", 256'(m_data), 256'(ec));
          end
        end
      end
    end
  end

  // C BRAM model: one-cycle read latency, garbage on the bus otherwise.
  initial begin : cram
    logic rdp;
    logic [AW-1:0] ra;
    C_USR_dout = '0;
    forever begin
      @(negedge clk);
      rdp = C_USR_rd;
      ra  = C_USR_addr;
      @(posedge clk);
      #1;
      if (rdp) C_USR_dout = cmem[ra];
      else for (int b = 0; b < N*MW; b++) C_USR_dout[b] = 1'($urandom_range(0, 1));
    end
  end

  initial begin : mready_drv
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    logic r;
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      r = s_ready;
      tick();
      C_MAT_wr = 1'b0;
      if (r) begin ok = 1; break; end
    end
    if (!ok) chk("s_handshake_timeout", 256'(0), 256'(1));
  endtask

  task automatic run(input int amode, input int bmode, input int gap, input int mrm,
                     input bit inj, input bit abort);
    logic [N*W-1:0] row_a, row_b;
    longint s;
    int e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (amode == 0) ? W'(c+1) : (amode == 1) ? W'(r == c) : W'($urandom);
        mb[r][c] = (bmode == 0) ? W'(c+1) : (bmode == 1) ? W'(r == c) : W'($urandom);
      end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        row_a[c*W +: W] = ma[r][c];
        row_b[c*W +: W] = mb[r][c];
      end
      exp_a.push_back({AW'(r), row_a});
      exp_b.push_back({AW'(r), row_b});
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        exp_c.push_back(MW'(s));
      end
    acc_cnt = 0; start_cycles = 0; rd_cnt = 0; mr_mode = mrm;

    for (e = 0; e < 2*N*N; e++) begin
      if (abort && e == N*N + 2*N + 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 256'({s_ready, m_valid, busy, A_USR_wr, B_USR_wr, C_USR_rd, start}), 256'(0));
        chk("rst_addr", 256'({A_USR_addr, B_USR_addr, C_USR_addr}), 256'(0));
        chk("rst_din", 256'({A_USR_din, B_USR_din}), 256'(0));
        chk("rst_mdata", 256'(m_data), 256'(0));
        s_valid = 1'b0; C_MAT_wr = 1'b0;
        exp_a.delete(); exp_b.delete(); exp_c.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      C_MAT_wr = inj && e < N*N && (e % 5 == 2);
      send((e < N*N) ? ma[e/N][e%N] : mb[(e-N*N)/N][(e-N*N)%N]);
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    s_valid = 1'b0;

    for (int t = 0; t < 50 && start_cycles < 3; t++) tick();
    repeat (4) tick();
    chk("start_len", 256'(start_cycles), 256'(3));
    chk("ab_rows_written", 256'(exp_a.size() + exp_b.size()), 256'(0));

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(amem[i][k*W +: W]) * longint'(bmem[k][j*W +: W]);
        cmem[i][j*MW +: MW] = MW'(s);
      end

    for (int p = 0; p < N; p++) begin
      repeat ($urandom_range(1, 4)) tick();
      if (p == N-1) begin
        chk("no_read_before_last_pulse", 256'(rd_cnt), 256'(0));
        chk("busy_in_wait", 256'(busy), 256'(1));
      end
      C_MAT_wr = 1'b1;
      tick();
      C_MAT_wr = 1'b0;
    end

    for (int t = 0; t < 3000 && busy; t++) tick();
    tick();
    chk("c_all_drained", 256'(exp_c.size()), 256'(0));
    chk("c_rows_read", 256'(rd_cnt), 256'(N));
    chk("start_total", 256'(start_cycles), 256'(3));
    chk("busy_end", 256'(busy), 256'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; C_MAT_wr = 1'b0; mr_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 256'({s_ready, m_valid, busy, A_USR_wr, B_USR_wr, C_USR_rd, start, m_data}), 256'(0));
    rst_n = 1'b1;
    tick();
    run(0, 0, 0, 0, 0, 0);
    run(1, 0, 0, 1, 0, 0);
    run(0, 0, 2, 0, 0, 0);
    run(2, 2, 0, 0, 0, 1);
    run(0, 0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 1, 0);
    run(2, 2, $urandom_range(0, 2), 2, 1, 0);
    run(2, 1, 1, 1, 0, 0);
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
